// File: rtl/vga_screen_mux.sv
// vga_screen_mux: picks one of NUM_SCREENS pixel streams, switching only at frame boundaries
module vga_screen_mux #(
  parameter int NUM_SCREENS = 4,
  parameter int COLOR_W = 8,
  parameter int DEBOUNCE_CYCLES = 1_080_000,
  parameter logic VSYNC_ACTIVE = 1'b0,
  localparam int SEL_W = NUM_SCREENS > 2 ? $clog2(NUM_SCREENS) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           key_n,
  input  logic [SEL_W-1:0]               sel_direct,
  input  logic                           sel_load,
  input  logic                           vsync,
  input  logic                           disp_en,
  input  logic [NUM_SCREENS*3*COLOR_W-1:0] rgb_in,
  output logic [COLOR_W-1:0]             r_out,
  output logic [COLOR_W-1:0]             g_out,
  output logic [COLOR_W-1:0]             b_out,
  output logic                           de_out,
  output logic [SEL_W-1:0]               sel,
  output logic [SEL_W-1:0]               sel_pending,
  output logic                           switch_busy
);
  localparam int CNT_W = DEBOUNCE_CYCLES > 2 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PIX_W = 3 * COLOR_W;
  logic k1, k2, db, vs_q;
  logic [CNT_W-1:0] cnt;
  logic [PIX_W-1:0] pix;
  logic settle, press, boundary, load_ok;
  always_comb begin
    settle = k2 != db && cnt == CNT_W'(DEBOUNCE_CYCLES - 1);
    press = settle && !k2;
    boundary = vsync == VSYNC_ACTIVE && vs_q != VSYNC_ACTIVE;
    load_ok = sel_load && int'(sel_direct) < NUM_SCREENS;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k1 <= 1'b1;
      k2 <= 1'b1;
      db <= 1'b1;
      cnt <= '0;
      vs_q <= ~VSYNC_ACTIVE;
      sel <= '0;
      sel_pending <= '0;
      pix <= '0;
      de_out <= 1'b0;
    end else begin
      k1 <= key_n;
      k2 <= k1;
      cnt <= (k2 == db || settle) ? '0 : cnt + CNT_W'(1);
      if (settle) db <= k2;
      vs_q <= vsync;
      if (boundary) sel <= sel_pending;
      if (load_ok) sel_pending <= sel_direct;
      else if (press && !sel_load)
        sel_pending <= sel_pending == SEL_W'(NUM_SCREENS - 1) ? '0 : sel_pending + SEL_W'(1);
      pix <= disp_en ? rgb_in[int'(sel)*PIX_W +: PIX_W] : '0;
      de_out <= disp_en;
    end
  end
  assign {r_out, g_out, b_out} = pix;
  assign switch_busy = sel_pending != sel;
endmodule

// File: tb/tb_vga_screen_mux.sv
// tb_vga_screen_mux: directed and randomized checks against a frame-level selection model
module tb_vga_screen_mux;
  localparam int N = 4;
  localparam int DEB = 4;
  localparam logic VA = 1'b0;
  logic clk = 0, rst_n, key_n, sel_load, vsync, disp_en;
  logic [1:0] sel_direct;
  logic [N*24-1:0] rgb_in;
  logic [7:0] r_out, g_out, b_out;
  logic de_out, switch_busy;
  logic [1:0] sel, sel_pending;
  logic [2:0] sel_direct5, sel5, pend5;
  logic sel_load5, de5, busy5;
  logic [7:0] r5, g5, b5;
  int checks = 0, failures = 0, n = 0;
  logic m_k1, m_k2, m_db, m_vsp, m_de;
  int run;
  logic [1:0] m_sel, m_pend;
  logic [23:0] m_rgb;
  wire [29:0] dut_v = {r_out, g_out, b_out, de_out, sel, sel_pending, switch_busy};
  wire [29:0] exp_v = {m_rgb, m_de, m_sel, m_pend, m_pend != m_sel};

  vga_screen_mux #(.NUM_SCREENS(N), .COLOR_W(8), .DEBOUNCE_CYCLES(DEB), .VSYNC_ACTIVE(VA)) dut (
    .clk(clk), .rst_n(rst_n), .key_n(key_n), .sel_direct(sel_direct), .sel_load(sel_load),
    .vsync(vsync), .disp_en(disp_en), .rgb_in(rgb_in), .r_out(r_out), .g_out(g_out),
    .b_out(b_out), .de_out(de_out), .sel(sel), .sel_pending(sel_pending), .switch_busy(switch_busy));

  vga_screen_mux #(.NUM_SCREENS(5), .COLOR_W(8), .DEBOUNCE_CYCLES(DEB), .VSYNC_ACTIVE(VA)) u5 (
    .clk(clk), .rst_n(rst_n), .key_n(1'b1), .sel_direct(sel_direct5), .sel_load(sel_load5),
    .vsync(1'b1), .disp_en(1'b0), .rgb_in('0), .r_out(r5), .g_out(g5), .b_out(b5),
    .de_out(de5), .sel(sel5), .sel_pending(pend5), .switch_busy(busy5));

  always #5 clk = ~clk;

  task automatic cyc();
    logic press, bnd;
    @(posedge clk);
    n++;
    if (!rst_n) begin
      m_k1 = 1; m_k2 = 1; m_db = 1; run = 0; m_vsp = ~VA;
      m_sel = 0; m_pend = 0; m_rgb = 0; m_de = 0;
    end else begin
      press = 0;
      run = (m_k2 !== m_db) ? run + 1 : 0;
      if (run == DEB) begin m_db = m_k2; run = 0; press = !m_db; end
      m_k2 = m_k1; m_k1 = key_n;
      bnd = vsync == VA && m_vsp != VA;
      m_vsp = vsync;
      m_rgb = disp_en ? rgb_in[int'(m_sel)*24 +: 24] : 24'h0;
      m_de = disp_en;
      if (bnd) m_sel = m_pend;
      if (sel_load) begin
        if (int'(sel_direct) < N) m_pend = sel_direct;
      end else if (press) m_pend = 2'((int'(m_pend) + 1) % N);
    end
    #1;
  endtask

  task automatic hold(input int k, input string tag);
    for (int i = 0; i < k; i++) begin
      cyc();
      checks++;
      if (dut_v !== exp_v) begin
        failures++;
        $display("FAIL %s cyc=%0d dut=%h exp=%h", tag, n, dut_v, exp_v);
      end
    end
  endtask

  task automatic frame();
    vsync = VA; hold(1, "frame");
    vsync = ~VA; hold(1, "frame");
  endtask

  task automatic test_reset();
    rst_n = 0; key_n = 1; sel_load = 0; sel_direct = 0; vsync = ~VA; disp_en = 1;
    sel_load5 = 0; sel_direct5 = 0; rgb_in = '1;
    cyc(); cyc();
    checks++;
    if (dut_v !== 30'h0) begin failures++; $display("FAIL reset dut=%h exp=0", dut_v); end
    rst_n = 1; disp_en = 0;
    hold(2, "reset_model");
  endtask

  task automatic test_press();
    key_n = 0; hold(10, "press");
    key_n = 1; hold(8, "press");
    checks++;
    if ({sel, sel_pending, switch_busy} !== {2'd0, 2'd1, 1'b1}) begin
      failures++; $display("FAIL press_pending sel=%0d pend=%0d busy=%b exp 0 1 1", sel, sel_pending, switch_busy);
    end
    vsync = VA; hold(1, "press");
    checks++;
    if ({sel, switch_busy} !== {2'd1, 1'b0}) begin
      failures++; $display("FAIL press_apply sel=%0d busy=%b exp 1 0", sel, switch_busy);
    end
    vsync = ~VA; hold(2, "press");
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 6; i++) begin key_n = i[0]; hold(2, "bounce"); end
    key_n = 0; hold(10, "bounce");
    key_n = 1; hold(8, "bounce");
    checks++;
    if (sel_pending !== 2'd2) begin
      failures++; $display("FAIL bounce_once pend=%0d exp 2", sel_pending);
    end
  endtask

  task automatic test_wrap();
    sel_load = 1; sel_direct = 0; hold(1, "wrap");
    sel_load = 0; frame();
    for (int i = 1; i <= 4; i++) begin
      key_n = 0; hold(8, "wrap");
      key_n = 1; hold(8, "wrap");
      checks++;
      if (sel_pending !== 2'(i % N)) begin
        failures++; $display("FAIL wrap_step%0d pend=%0d exp %0d", i, sel_pending, i % N);
      end
    end
    frame();
    checks++;
    if ({sel, switch_busy} !== 3'b000) begin
      failures++; $display("FAIL wrap_apply sel=%0d busy=%b exp 0 0", sel, switch_busy);
    end
  endtask

  task automatic test_load();
    key_n = 0; hold(5, "load");
    sel_load = 1; sel_direct = 2; hold(1, "load");
    sel_load = 0; hold(3, "load");
    key_n = 1; hold(8, "load");
    checks++;
    if (sel_pending !== 2'd2) begin
      failures++; $display("FAIL load_vs_press pend=%0d exp 2", sel_pending);
    end
    sel_load5 = 1;
    sel_direct5 = 3; cyc();
    sel_direct5 = 5; cyc();
    sel_direct5 = 7; cyc();
    sel_load5 = 0; cyc();
    checks++;
    if (pend5 !== 3'd3) begin failures++; $display("FAIL load_ignore pend=%0d exp 3", pend5); end
    sel_load5 = 1; sel_direct5 = 4; cyc();
    sel_load5 = 0; cyc();
    checks++;
    if (pend5 !== 3'd4) begin failures++; $display("FAIL load_top pend=%0d exp 4", pend5); end
    frame();
  endtask

  task automatic test_pixels();
    logic [23:0] want [3] = '{24'hFF0080, 24'hFF0080, 24'h000000};
    logic de_want [3] = '{1'b1, 1'b1, 1'b0};
    rgb_in = {$urandom(), $urandom(), $urandom()};
    rgb_in[48 +: 24] = 24'hFF0080;
    sel_load = 1; sel_direct = 2; hold(1, "pixels");
    sel_load = 0; frame();
    for (int i = 0; i < 3; i++) begin
      disp_en = de_want[i]; hold(1, "pixels");
      checks++;
      if ({r_out, g_out, b_out, de_out} !== {want[i], de_want[i]}) begin
        failures++; $display("FAIL pixel%0d rgb=%h de=%b exp %h %b", i, {r_out, g_out, b_out}, de_out, want[i], de_want[i]);
      end
    end
  endtask

  task automatic test_midreset();
    sel_load = 1; sel_direct = 3; hold(1, "midreset");
    sel_load = 0; frame();
    disp_en = 1; key_n = 0; hold(4, "midreset");
    rst_n = 0; key_n = 1; cyc();
    checks++;
    if (dut_v !== 30'h0) begin failures++; $display("FAIL midreset dut=%h exp=0", dut_v); end
    rst_n = 1; disp_en = 0; hold(10, "midreset");
    checks++;
    if ({sel, sel_pending} !== 4'h0) begin
      failures++; $display("FAIL midreset_nopress sel=%0d pend=%0d exp 0 0", sel, sel_pending);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      rst_n = ($urandom % 600) != 0;
      if ($urandom % 10 == 0) key_n = ~key_n;
      sel_load = ($urandom % 25) == 0;
      sel_direct = 2'($urandom);
      vsync = (i % 45) < 3 ? VA : ~VA;
      disp_en = 1'($urandom);
      rgb_in = {$urandom(), $urandom(), $urandom()};
      cyc();
      checks++;
      if (dut_v !== exp_v) begin
        failures++; $display("FAIL random cyc=%0d dut=%h exp=%h", n, dut_v, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_wrap();
    test_load();
    test_pixels();
    test_midreset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
